run_ctrl: RTL and testbench

//  Execution sequencer for the single-cycle CPU core. Produces cpu_en, the global advance enable

---
 rtl/run_ctrl_if.sv | 77 +++++++
 rtl/run_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_run_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/run_ctrl_if.sv
// -----------------------------------------------------------------------------
// run_ctrl_if
// Bundle of the run-control signals exchanged between the execution sequencer
// (run_ctrl) and the surrounding system (top-level trigger, host debug port and
// the CPU core).
//
// Parameters
//   ADDR_W   width of pc / bp_addr
//   CNT_W    width of the retired-instruction counter
//
// Signals (direction seen from the sequencer, i.e. the slave modport)
//   trigger     in   level input, rising edge requests a run
//   run_req     in   pulse, free-run from IDLE/HALT
//   step_req    in   pulse, execute a burst of instructions from IDLE/HALT
//   halt_req    in   pulse, stop at the next cycle boundary
//   bp_en       in   breakpoint enable
//   bp_addr     in   breakpoint PC
//   pc          in   current core PC
//   instr       in   instruction at pc
//   cpu_en      out  core advances this cycle
//   state       out  00 IDLE, 01 RUN, 10 STEP, 11 HALT
//   halt_cause  out  00 NONE, 01 HOST, 10 BP/STEP-DONE, 11 EBREAK
//   retired     out  number of retired instructions (saturating)
//
// The master modport is the side that drives the requests and observes the
// sequencer (system / testbench); the slave modport is the sequencer itself.
// -----------------------------------------------------------------------------
interface run_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
);

  logic              trigger;
  logic              run_req;
  logic              step_req;
  logic              halt_req;
  logic              bp_en;
  logic [ADDR_W-1:0] bp_addr;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       instr;

  logic              cpu_en;
  logic [1:0]        state;
  logic [1:0]        halt_cause;
  logic [CNT_W-1:0]  retired;

  modport master (
    output trigger,
    output run_req,
    output step_req,
    output halt_req,
    output bp_en,
    output bp_addr,
    output pc,
    output instr,
    input  cpu_en,
    input  state,
    input  halt_cause,
    input  retired
  );

  modport slave (
    input  trigger,
    input  run_req,
    input  step_req,
    input  halt_req,
    input  bp_en,
    input  bp_addr,
    input  pc,
    input  instr,
    output cpu_en,
    output state,
    output halt_cause,
    output retired
  );

endinterface : run_ctrl_if

// File: rtl/run_ctrl.sv
// -----------------------------------------------------------------------------
// run_ctrl
// Execution sequencer for the single-cycle CPU core. Generates cpu_en, the
// global advance enable that gates PC update, register-file write and
// data-memory write. The core can be run freely, single-stepped in bursts of
// STEP_BURST instructions, or halted by a host request, a PC breakpoint or an
// EBREAK instruction. Retired instructions are counted for the host.
//
// Parameters
//   ADDR_W      width of pc / bp_addr (must match the interface)
//   CNT_W       width of the retired counter (must match the interface)
//   STEP_BURST  instructions executed per step request (>= 1)
//   EBREAK_OP   instruction encoding that halts the core
//
// Ports
//   clk   system clock, all state on the rising edge
//   rst   synchronous, active-high reset
//   bus   run_ctrl_if.slave: requests, breakpoint, pc/instr in;
//         cpu_en, state, halt_cause, retired out
//
// Timing
//   cpu_en is purely combinational from the registered state and this
//   cycle's inputs, so a halt condition suppresses the very instruction that
//   raised it. state / halt_cause reflect the decision one cycle later.
// -----------------------------------------------------------------------------
module run_ctrl #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned STEP_BURST = 1,
  parameter logic [31:0] EBREAK_OP  = 32'h00100073
) (
  input  logic     clk,
  input  logic     rst,
  run_ctrl_if.slave bus
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_HALT = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    CS_NONE   = 2'b00,
    CS_HOST   = 2'b01,
    CS_BP     = 2'b10,   // breakpoint hit or step burst completed
    CS_EBREAK = 2'b11
  } cause_e;

  // Step counter only needs to hold STEP_BURST; keep at least one bit.
  localparam int unsigned SC_W = (STEP_BURST < 2) ? 1 : $clog2(STEP_BURST + 1);
  localparam logic [SC_W-1:0] STEP_INIT = SC_W'(STEP_BURST);
  localparam logic [SC_W-1:0] STEP_LAST = SC_W'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q,    state_d;
  cause_e           cause_q,    cause_d;
  logic [SC_W-1:0]  step_cnt_q, step_cnt_d;
  logic             skip_q,     skip_d;      // ignore breakpoint on first instr after resume
  logic             trig_q;                  // previous trigger level for edge detect
  logic [CNT_W-1:0] retired_q;

  // ---------------------------------------------------------------------------
  // Hit detection
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] pc_c;
  logic [ADDR_W-1:0] bp_addr_c;
  logic              start;
  logic              ebreak_hit;
  logic              bp_hit;
  logic              en_c;

  assign pc_c      = bus.pc;
  assign bp_addr_c = bus.bp_addr;

  // A run request is either an explicit pulse or a rising edge on trigger.
  assign start      = bus.run_req | (bus.trigger & ~trig_q);
  // EBREAK is never masked by skip: resuming onto an EBREAK halts again.
  assign ebreak_hit = (bus.instr == EBREAK_OP);
  // skip lets a resume from a breakpoint execute the instruction at bp_addr.
  assign bp_hit     = bus.bp_en & (pc_c == bp_addr_c) & ~skip_q;

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here receives a default before the case
  // statement, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    step_cnt_d = step_cnt_q;
    skip_d     = skip_q;
    en_c       = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        // An EBREAK halt is sticky: only reset can leave it.
        if (cause_q != CS_EBREAK) begin
          if (start) begin
            state_d = ST_RUN;
            cause_d = CS_NONE;
            skip_d  = 1'b1;
          end else if (bus.step_req) begin
            state_d    = ST_STEP;
            cause_d    = CS_NONE;
            skip_d     = 1'b1;
            step_cnt_d = STEP_INIT;
          end else if (bus.halt_req && (state_q == ST_IDLE)) begin
            state_d = ST_HALT;
            cause_d = CS_HOST;
          end
        end
      end

      ST_RUN, ST_STEP: begin
        if (bus.halt_req) begin
          state_d = ST_HALT;
          cause_d = CS_HOST;
        end else if (ebreak_hit) begin
          state_d = ST_HALT;
          cause_d = CS_EBREAK;
        end else if (bp_hit) begin
          state_d = ST_HALT;
          cause_d = CS_BP;
        end else begin
          en_c   = 1'b1;
          skip_d = 1'b0;
          if (state_q == ST_STEP) begin
            step_cnt_d = step_cnt_q - STEP_LAST;
            // Last instruction of the burst executes, then the core stops.
            if (step_cnt_q == STEP_LAST) begin
              state_d = ST_HALT;
              cause_d = CS_BP;
            end
          end
        end
      end

      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cause_q    <= CS_NONE;
      step_cnt_q <= '0;
      skip_q     <= 1'b0;
      trig_q     <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      step_cnt_q <= step_cnt_d;
      skip_q     <= skip_d;
      trig_q     <= bus.trigger;
      // Saturate rather than wrap so the host never sees a small count
      // after a very long run.
      if (en_c && (retired_q != '1)) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Reset aborts execution in the same cycle it is asserted.
  assign bus.cpu_en     = en_c & ~rst;
  assign bus.state      = state_q;
  assign bus.halt_cause = cause_q;
  assign bus.retired    = retired_q;

endmodule : run_ctrl

// File: tb/tb_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_run_ctrl
// Directed bench for run_ctrl. A driver applies one input vector per clock
// cycle and queues the hand-computed response for that cycle; a monitor pops
// the queue on the falling edge and compares cpu_en, state, halt_cause and
// retired. A second instance with a 4-bit counter and STEP_BURST=1 covers
// counter saturation and single-instruction stepping.
// -----------------------------------------------------------------------------
module tb_run_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] EB  = 32'h0010_0073;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_STEP = 2'b10;
  localparam logic [1:0] S_HALT = 2'b11;

  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_HOST = 2'b01;
  localparam logic [1:0] C_BP   = 2'b10;
  localparam logic [1:0] C_EB   = 2'b11;

  typedef struct {
    int          cyc;
    int          dut;
    string       name;
    logic        en;
    logic [1:0]  st;
    logic [1:0]  cause;
    logic [31:0] ret;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  run_ctrl_if #(.ADDR_W(32), .CNT_W(32)) bus ();
  run_ctrl_if #(.ADDR_W(32), .CNT_W(4))  bus2 ();

  run_ctrl #(
    .ADDR_W(32), .CNT_W(32), .STEP_BURST(3), .EBREAK_OP(32'h0010_0073)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  run_ctrl #(
    .ADDR_W(32), .CNT_W(4), .STEP_BURST(1), .EBREAK_OP(32'h0010_0073)
  ) dut_sat (
    .clk(clk), .rst(rst2), .bus(bus2)
  );

  // One vector on the main instance: inputs for this cycle and the expected
  // cpu_en for these inputs plus the registered outputs seen in this cycle.
  task automatic vec(input logic r, tr, rr, sr, hr,
                     input logic [31:0] pcv, iv,
                     input logic een, input logic [1:0] est, ec,
                     input logic [31:0] eret, input string nm);
    exp_t e;
    @(posedge clk); #1;
    rst          = r;
    bus.trigger  = tr;
    bus.run_req  = rr;
    bus.step_req = sr;
    bus.halt_req = hr;
    bus.pc       = pcv;
    bus.instr    = iv;
    e.cyc = cyc; e.dut = 0; e.name = nm;
    e.en = een; e.st = est; e.cause = ec; e.ret = eret;
    exp_q.push_back(e);
  endtask

  // One vector on the saturation instance (pc/instr held at 0/NOP).
  task automatic vec2(input logic r, rr, sr, hr,
                      input logic een, input logic [1:0] est, ec,
                      input logic [31:0] eret, input string nm);
    exp_t e;
    @(posedge clk); #1;
    rst2          = r;
    bus2.run_req  = rr;
    bus2.step_req = sr;
    bus2.halt_req = hr;
    e.cyc = cyc; e.dut = 1; e.name = nm;
    e.en = een; e.st = est; e.cause = ec; e.ret = eret;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every queued expectation in the cycle it belongs to.
  initial begin
    exp_t        e;
    logic        a_en;
    logic [1:0]  a_st, a_c;
    logic [31:0] a_ret;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        if (e.dut == 0) begin
          a_en = bus.cpu_en; a_st = bus.state; a_c = bus.halt_cause; a_ret = bus.retired;
        end else begin
          a_en = bus2.cpu_en; a_st = bus2.state; a_c = bus2.halt_cause;
          a_ret = {28'd0, bus2.retired};
        end
        n_vec++;
        if (a_en !== e.en || a_st !== e.st || a_c !== e.cause || a_ret !== e.ret) begin
          n_miss++;
          $display("FAIL %s (cyc %0d dut %0d): got en=%b st=%b cause=%b ret=%0d, expected en=%b st=%b cause=%b ret=%0d",
                   e.name, e.cyc, e.dut, a_en, a_st, a_c, a_ret, e.en, e.st, e.cause, e.ret);
        end
      end
    end
  end

  // Watchdog: the stimulus is bounded, but never let the run hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    bus.trigger = 0; bus.run_req = 0; bus.step_req = 0; bus.halt_req = 0;
    bus.bp_en = 0; bus.bp_addr = 0; bus.pc = 0; bus.instr = NOP;
    bus2.trigger = 0; bus2.run_req = 0; bus2.step_req = 0; bus2.halt_req = 0;
    bus2.bp_en = 0; bus2.bp_addr = 0; bus2.pc = 0; bus2.instr = NOP;

    // Reset, then free run for ten instructions and stop from the host.
    vec(1, 0, 0, 0, 0, 0, NOP, 0, S_IDLE, C_NONE, 0, "reset_state");
    vec(1, 0, 1, 0, 0, 0, NOP, 0, S_IDLE, C_NONE, 0, "rst_gates_en");
    vec(0, 0, 1, 0, 0, 0, NOP, 0, S_IDLE, C_NONE, 0, "idle_run_req");
    for (int i = 0; i < 10; i++)
      vec(0, 0, 0, 0, 0, 4 * i, NOP, 1, S_RUN, C_NONE, i, "run_nop");
    vec(0, 0, 0, 0, 1, 40, NOP, 0, S_RUN, C_NONE, 10, "halt_req_run");
    vec(0, 0, 0, 0, 0, 40, NOP, 0, S_HALT, C_HOST, 10, "halted_host");

    // Breakpoint at 0x10, then resume executes the instruction at 0x10.
    bus.bp_en = 1; bus.bp_addr = 32'h10;
    vec(0, 0, 1, 0, 0, 32'h08, NOP, 0, S_HALT, C_HOST, 10, "resume_req");
    vec(0, 0, 0, 0, 0, 32'h08, NOP, 1, S_RUN, C_NONE, 10, "resume_exec");
    vec(0, 0, 0, 0, 0, 32'h0C, NOP, 1, S_RUN, C_NONE, 11, "run_0c");
    vec(0, 0, 0, 0, 0, 32'h10, NOP, 0, S_RUN, C_NONE, 12, "bp_hit");
    vec(0, 0, 0, 0, 0, 32'h10, NOP, 0, S_HALT, C_BP, 12, "bp_halted");
    vec(0, 0, 1, 0, 0, 32'h10, NOP, 0, S_HALT, C_BP, 12, "bp_run_req");
    vec(0, 0, 0, 0, 0, 32'h10, NOP, 1, S_RUN, C_NONE, 12, "bp_skip_exec");
    vec(0, 0, 0, 0, 0, 32'h14, NOP, 1, S_RUN, C_NONE, 13, "no_rehalt");
    vec(0, 0, 0, 0, 1, 32'h18, NOP, 0, S_RUN, C_NONE, 14, "halt_req2");
    vec(0, 0, 0, 0, 0, 32'h18, NOP, 0, S_HALT, C_HOST, 14, "halted_host2");
    bus.bp_en = 0;

    // Step bursts of three from IDLE and again from HALT.
    vec(1, 0, 0, 0, 0, 0, NOP, 0, S_HALT, C_HOST, 14, "rst_from_halt");
    vec(0, 0, 0, 1, 0, 0, NOP, 0, S_IDLE, C_NONE, 0, "idle_step_req");
    for (int i = 0; i < 3; i++)
      vec(0, 0, 0, 0, 0, 4 * i, NOP, 1, S_STEP, C_NONE, i, "step_exec");
    vec(0, 0, 0, 1, 0, 12, NOP, 0, S_HALT, C_BP, 3, "step_done_restep");
    for (int i = 0; i < 3; i++)
      vec(0, 0, 0, 0, 0, 12 + 4 * i, NOP, 1, S_STEP, C_NONE, 3 + i, "step2_exec");
    vec(0, 0, 0, 0, 0, 24, NOP, 0, S_HALT, C_BP, 6, "step2_done");

    // halt_req and breakpoint in the same cycle: host wins.
    bus.bp_en = 1; bus.bp_addr = 32'h30;
    vec(0, 0, 1, 0, 0, 32'h28, NOP, 0, S_HALT, C_BP, 6, "resume_req3");
    vec(0, 0, 0, 0, 0, 32'h28, NOP, 1, S_RUN, C_NONE, 6, "run_28");
    vec(0, 0, 0, 0, 0, 32'h2C, NOP, 1, S_RUN, C_NONE, 7, "run_2c");
    vec(0, 0, 0, 0, 1, 32'h30, NOP, 0, S_RUN, C_NONE, 8, "halt_and_bp");
    vec(0, 0, 0, 0, 0, 32'h30, NOP, 0, S_HALT, C_HOST, 8, "halt_beats_bp");
    bus.bp_en = 0;

    // EBREAK halts and is sticky against run, step and trigger.
    vec(0, 0, 1, 0, 0, 32'h30, NOP, 0, S_HALT, C_HOST, 8, "resume_req4");
    vec(0, 0, 0, 0, 0, 32'h30, NOP, 1, S_RUN, C_NONE, 8, "run_30");
    vec(0, 0, 0, 0, 0, 32'h34, EB,  0, S_RUN, C_NONE, 9, "ebreak_hit");
    vec(0, 0, 1, 0, 0, 32'h34, EB,  0, S_HALT, C_EB, 9, "eb_ignore_run");
    vec(0, 0, 0, 1, 0, 32'h34, NOP, 0, S_HALT, C_EB, 9, "eb_ignore_step");
    vec(0, 1, 0, 0, 0, 32'h34, NOP, 0, S_HALT, C_EB, 9, "eb_ignore_trig");
    vec(0, 0, 0, 0, 0, 32'h34, NOP, 0, S_HALT, C_EB, 9, "eb_sticky");
    vec(1, 0, 0, 0, 0, 32'h34, NOP, 0, S_HALT, C_EB, 9, "rst_eb");
    vec(0, 0, 0, 0, 0, 0, NOP, 0, S_IDLE, C_NONE, 0, "eb_cleared");

    // trigger held high starts only once.
    vec(0, 1, 0, 0, 0, 0, NOP, 0, S_IDLE, C_NONE, 0, "trig_rise");
    for (int i = 0; i < 5; i++)
      vec(0, 1, 0, 0, 0, 4 * i, NOP, 1, S_RUN, C_NONE, i, "trig_run");
    vec(0, 1, 0, 0, 1, 20, NOP, 0, S_RUN, C_NONE, 5, "trig_halt");
    for (int i = 0; i < 13; i++)
      vec(0, 1, 0, 0, 0, 20, NOP, 0, S_HALT, C_HOST, 5, "trig_held");
    vec(0, 0, 0, 0, 0, 20, NOP, 0, S_HALT, C_HOST, 5, "trig_low");
    vec(0, 1, 0, 0, 0, 20, NOP, 0, S_HALT, C_HOST, 5, "trig_rise2");
    // First instruction after resume is EBREAK: skip must not mask it.
    vec(0, 1, 0, 0, 0, 20, EB,  0, S_RUN, C_NONE, 5, "eb_with_skip");
    vec(0, 0, 0, 0, 0, 20, NOP, 0, S_HALT, C_EB, 5, "eb_skip_halted");

    // Reset in the middle of a run aborts immediately.
    vec(1, 0, 0, 0, 0, 0, NOP, 0, S_HALT, C_EB, 5, "rst_eb2");
    vec(0, 0, 1, 0, 0, 0, NOP, 0, S_IDLE, C_NONE, 0, "idle_run_req2");
    for (int i = 0; i < 3; i++)
      vec(0, 0, 0, 0, 0, 4 * i, NOP, 1, S_RUN, C_NONE, i, "run_pre_rst");
    vec(1, 0, 0, 0, 0, 12, NOP, 0, S_RUN, C_NONE, 3, "rst_mid_run");
    vec(0, 0, 0, 0, 0, 0, NOP, 0, S_IDLE, C_NONE, 0, "rst_run_idle");

    // halt_req in IDLE, then run beats step.
    vec(0, 0, 0, 0, 1, 0, NOP, 0, S_IDLE, C_NONE, 0, "idle_halt_req");
    vec(0, 0, 1, 1, 0, 0, NOP, 0, S_HALT, C_HOST, 0, "run_and_step");
    vec(0, 0, 0, 0, 0, 0, NOP, 1, S_RUN, C_NONE, 0, "run_beats_step");
    vec(0, 0, 0, 0, 1, 4, NOP, 0, S_RUN, C_NONE, 1, "halt_req3");
    vec(0, 0, 0, 0, 0, 4, NOP, 0, S_HALT, C_HOST, 1, "halted_host3");

    // Saturation on the 4-bit counter instance, then one single step.
    vec2(1, 0, 0, 0, 0, S_IDLE, C_NONE, 0, "sat_reset");
    vec2(0, 1, 0, 0, 0, S_IDLE, C_NONE, 0, "sat_run_req");
    for (int i = 0; i < 16; i++)
      vec2(0, 0, 0, 0, 1, S_RUN, C_NONE, i, "sat_count");
    vec2(0, 0, 0, 0, 1, S_RUN, C_NONE, 15, "sat_hold");
    vec2(0, 0, 0, 0, 1, S_RUN, C_NONE, 15, "sat_hold2");
    vec2(0, 0, 0, 1, 0, S_RUN, C_NONE, 15, "sat_halt");
    vec2(0, 0, 1, 0, 0, S_HALT, C_HOST, 15, "sat_step_req");
    vec2(0, 0, 0, 0, 1, S_STEP, C_NONE, 15, "step1_exec");
    vec2(0, 0, 0, 0, 0, S_HALT, C_BP, 15, "step1_done");

    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_run_ctrl
